// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: cpu word, access size,
// arbitration owner and arbiter state encodings.
package mem_port_arbiter_pkg;

  typedef logic [31:0] cpu_word;

  typedef enum logic [1:0] {
    MODE_BYTE = 2'd0,
    MODE_HALF = 2'd1,
    MODE_WORD = 2'd2
  } mem_mode_t;

  typedef enum logic [1:0] {
    ARB_NONE = 2'd0,
    ARB_IF   = 2'd1,
    ARB_LS   = 2'd2
  } arb_owner;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state;

endpackage

// File: rtl/arb_grant_fsm.sv
// Grant FSM: holds state, owner and LS streak; decides IF/LS grants.
// Ports: clk, reset (async low), ifReq, lsReq, memValid -> ifGnt, lsGnt, busy, owner.
module arb_grant_fsm
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     ifReq,
  input  logic     lsReq,
  input  logic     memValid,
  output logic     ifGnt,
  output logic     lsGnt,
  output logic     busy,
  output arb_owner owner
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

  arb_state      state;
  logic [SW-1:0] streak;
  logic          canGrant;
  logic          forceIf;

  // A new grant may issue when idle, or in the cycle the
  // outstanding access completes (zero-bubble handoff).
  always_comb begin
    canGrant = reset && ((state == ARB_IDLE) || memValid);
    forceIf  = ifReq && (streak == LIM);
    lsGnt    = canGrant && lsReq && !forceIf;
    ifGnt    = canGrant && ifReq && !lsGnt;
  end

  assign busy = (state == ARB_WAIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ARB_IDLE;
      owner  <= ARB_NONE;
      streak <= '0;
    end else if (lsGnt) begin
      state <= ARB_WAIT;
      owner <= ARB_LS;
      if (!ifReq)
        streak <= '0;
      else if (streak != LIM)
        streak <= streak + 1'b1;
    end else if (ifGnt) begin
      state  <= ARB_WAIT;
      owner  <= ARB_IF;
      streak <= '0;
    end else if ((state == ARB_WAIT) && memValid) begin
      state <= ARB_IDLE;
      owner <= ARB_NONE;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one ram port between fetch (IF) and load/store (LS); LS priority
// with fetch anti-starvation. Optional stall counters under MEM_ARB_PERF_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_adr,
  output logic              if_gnt,
  output logic              if_valid,
  output cpu_word           if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  mem_mode_t         ls_mode,
  input  logic [ADDR_W-1:0] ls_adr,
  input  cpu_word           ls_wdata,
  output logic              ls_gnt,
  output logic              ls_valid,
  output cpu_word           ls_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output mem_mode_t         mem_mode,
  output logic [ADDR_W-1:0] mem_adr,
  output cpu_word           mem_wdata,
  input  cpu_word           mem_rdata,
  input  logic              mem_valid,
`ifdef MEM_ARB_PERF_EN
  output logic [31:0]       if_stall_cnt,
  output logic [31:0]       ls_stall_cnt,
`endif
  output logic              busy
);

  arb_owner owner;
  cpu_word  ifRdataQ;
  cpu_word  lsRdataQ;

  arb_grant_fsm #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_fsm (
    .clk     (clk),
    .reset   (reset),
    .ifReq   (if_req),
    .lsReq   (ls_req),
    .memValid(mem_valid),
    .ifGnt   (if_gnt),
    .lsGnt   (ls_gnt),
    .busy    (busy),
    .owner   (owner)
  );

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_mode  = MODE_WORD;
    mem_adr   = '0;
    mem_wdata = '0;
    unique case (1'b1)
      ls_gnt: begin
        mem_en    = 1'b1;
        mem_we    = ls_we;
        mem_mode  = ls_mode;
        mem_adr   = ls_adr;
        mem_wdata = ls_wdata;
      end
      if_gnt: begin
        mem_en  = 1'b1;
        mem_adr = if_adr;
      end
      default: ;
    endcase
  end

  // busy gates out stray completions seen while idle.
  assign if_valid = busy && mem_valid && (owner == ARB_IF);
  assign ls_valid = busy && mem_valid && (owner == ARB_LS);

  assign if_rdata = if_valid ? mem_rdata : ifRdataQ;
  assign ls_rdata = ls_valid ? mem_rdata : lsRdataQ;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ifRdataQ <= '0;
      lsRdataQ <= '0;
    end else begin
      if (if_valid) ifRdataQ <= mem_rdata;
      if (ls_valid) lsRdataQ <= mem_rdata;
    end
  end

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_stall_cnt <= '0;
      ls_stall_cnt <= '0;
    end else begin
      if (if_req && !if_gnt)
        if_stall_cnt <= if_stall_cnt + 32'd1;
      if (ls_req && !ls_gnt)
        ls_stall_cnt <= ls_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Inputs change on negedge; outputs are checked 1ns later.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_adr;
  logic        if_gnt;
  logic        if_valid;
  cpu_word     if_rdata;
  logic        ls_req;
  logic        ls_we;
  mem_mode_t   ls_mode;
  logic [31:0] ls_adr;
  cpu_word     ls_wdata;
  logic        ls_gnt;
  logic        ls_valid;
  cpu_word     ls_rdata;
  logic        mem_en;
  logic        mem_we;
  mem_mode_t   mem_mode;
  logic [31:0] mem_adr;
  cpu_word     mem_wdata;
  cpu_word     mem_rdata;
  logic        mem_valid;
  logic        busy;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] if_stall_cnt;
  logic [31:0] ls_stall_cnt;
`endif

  int nTests;
  int nFail;

  mem_port_arbiter #(
    .STARVE_LIMIT(4),
    .ADDR_W(32)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_adr   (if_adr),
    .if_gnt   (if_gnt),
    .if_valid (if_valid),
    .if_rdata (if_rdata),
    .ls_req   (ls_req),
    .ls_we    (ls_we),
    .ls_mode  (ls_mode),
    .ls_adr   (ls_adr),
    .ls_wdata (ls_wdata),
    .ls_gnt   (ls_gnt),
    .ls_valid (ls_valid),
    .ls_rdata (ls_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_mode (mem_mode),
    .mem_adr  (mem_adr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_valid(mem_valid),
`ifdef MEM_ARB_PERF_EN
    .if_stall_cnt(if_stall_cnt),
    .ls_stall_cnt(ls_stall_cnt),
`endif
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic nedge();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  // Grant pattern for the starvation run: 1 = IF, 0 = LS.
  logic [9:0] ifPat;

  initial begin
    nTests    = 0;
    nFail     = 0;
    reset     = 1'b0;
    if_req    = 1'b0;
    if_adr    = '0;
    ls_req    = 1'b0;
    ls_we     = 1'b0;
    ls_mode   = MODE_WORD;
    ls_adr    = '0;
    ls_wdata  = '0;
    mem_rdata = '0;
    mem_valid = 1'b0;
    ifPat     = 10'b10000_10000;

    // Reset state
    nedge(); settle();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_en",   32'(mem_en), 32'd0);
    chk("rst_mode", 32'(mem_mode), 32'(MODE_WORD));
    chk("rst_ifv",  32'(if_valid), 32'd0);
    chk("rst_ird",  if_rdata, 32'd0);
    nedge(); reset = 1'b1;

    // 1: lone fetch, response 2 cycles later
    nedge(); if_req = 1'b1; if_adr = 32'h10; settle();
    chk("t1_gnt",  32'(if_gnt), 32'd1);
    chk("t1_en",   32'(mem_en), 32'd1);
    chk("t1_adr",  mem_adr, 32'h10);
    chk("t1_we",   32'(mem_we), 32'd0);
    chk("t1_mode", 32'(mem_mode), 32'(MODE_WORD));
    nedge(); if_req = 1'b0; settle();
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_ifv0", 32'(if_valid), 32'd0);
    nedge(); mem_valid = 1'b1; mem_rdata = 32'hDEADBEEF; settle();
    chk("t1_ifv",  32'(if_valid), 32'd1);
    chk("t1_ird",  if_rdata, 32'hDEADBEEF);
    chk("t1_lsv",  32'(ls_valid), 32'd0);
    nedge(); mem_valid = 1'b0; mem_rdata = 32'h0; settle();
    chk("t1_hold", if_rdata, 32'hDEADBEEF);
    chk("t1_idle", 32'(busy), 32'd0);

    // 2: IF and LS together, LS first then zero-bubble IF
    nedge();
    if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0; ls_adr = 32'h40;
    settle();
    chk("t2_lsg",  32'(ls_gnt), 32'd1);
    chk("t2_ifg",  32'(if_gnt), 32'd0);
    chk("t2_adr",  mem_adr, 32'h40);
    nedge(); ls_req = 1'b0; settle();
    chk("t2_wait", 32'(if_gnt), 32'd0);
    nedge(); mem_valid = 1'b1; mem_rdata = 32'h11112222; settle();
    chk("t2_lsv",  32'(ls_valid), 32'd1);
    chk("t2_lsrd", ls_rdata, 32'h11112222);
    chk("t2_ifg2", 32'(if_gnt), 32'd1);
    chk("t2_adr2", mem_adr, 32'h10);
    nedge(); if_req = 1'b0; mem_valid = 1'b0; settle();
    chk("t2_busy", 32'(busy), 32'd1);
    nedge(); mem_valid = 1'b1; mem_rdata = 32'h33334444; settle();
    chk("t2_ifv",  32'(if_valid), 32'd1);
    chk("t2_ird",  if_rdata, 32'h33334444);
    chk("t2_lshd", ls_rdata, 32'h11112222);
    nedge(); mem_valid = 1'b0; settle();
    chk("t2_idle", 32'(busy), 32'd0);

    // 3: starvation guard; fresh reset so counters start at 0
    reset = 1'b0;
    nedge(); reset = 1'b1;
    nedge(); if_req = 1'b1; ls_req = 1'b1; mem_valid = 1'b1;
    mem_rdata = 32'h0BADF00D;
    for (int i = 0; i < 10; i++) begin
      if (i != 0) nedge();
      settle();
      chk($sformatf("t3_gnt%0d", i), {30'd0, if_gnt, ls_gnt},
          ifPat[i] ? 32'd2 : 32'd1);
    end
    nedge(); if_req = 1'b0; ls_req = 1'b0; mem_valid = 1'b0; settle();
`ifdef MEM_ARB_PERF_EN
    chk("t6_ifst", if_stall_cnt, 32'd8);
    chk("t6_lsst", ls_stall_cnt, 32'd2);
`endif
    chk("t3_busy", 32'(busy), 32'd1);
    nedge(); mem_valid = 1'b1; settle();
    chk("t3_ifv",  32'(if_valid), 32'd1);
    nedge(); mem_valid = 1'b0; settle();
    chk("t3_ird",  if_rdata, 32'h0BADF00D);

    // 4: half-word store
    nedge();
    ls_req = 1'b1; ls_we = 1'b1; ls_mode = MODE_HALF;
    ls_adr = 32'h80; ls_wdata = 32'h12345678;
    settle();
    chk("t4_lsg",  32'(ls_gnt), 32'd1);
    chk("t4_we",   32'(mem_we), 32'd1);
    chk("t4_wd",   mem_wdata, 32'h12345678);
    chk("t4_mode", 32'(mem_mode), 32'(MODE_HALF));
    nedge(); ls_req = 1'b0; ls_we = 1'b0; settle();
    chk("t4_we0",  32'(mem_we), 32'd0);
    nedge(); mem_valid = 1'b1; mem_rdata = 32'hAAAA5555; settle();
    chk("t4_lsv",  32'(ls_valid), 32'd1);
    chk("t4_ifv",  32'(if_valid), 32'd0);
    chk("t4_ird",  if_rdata, 32'h0BADF00D);
    nedge(); settle();
    // stray mem_valid while idle
    chk("t4_sifv", 32'(if_valid), 32'd0);
    chk("t4_slsv", 32'(ls_valid), 32'd0);
    chk("t4_sbsy", 32'(busy), 32'd0);
    nedge(); mem_valid = 1'b0;

    // 5: reset mid-transaction
    nedge(); if_req = 1'b1; if_adr = 32'h20; settle();
    chk("t5_gnt",  32'(if_gnt), 32'd1);
    nedge(); if_req = 1'b0; settle();
    chk("t5_busy", 32'(busy), 32'd1);
    nedge(); reset = 1'b0; settle();
    chk("t5_rbsy", 32'(busy), 32'd0);
    nedge(); reset = 1'b1;
    nedge(); mem_valid = 1'b1; mem_rdata = 32'h55AA55AA; settle();
    chk("t5_ifv",  32'(if_valid), 32'd0);
    chk("t5_lsv",  32'(ls_valid), 32'd0);
    chk("t5_busy2", 32'(busy), 32'd0);
    chk("t5_en",   32'(mem_en), 32'd0);
    chk("t5_ird",  if_rdata, 32'd0);
    nedge(); mem_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
